seq_scan_ctrl: RTL

Controller that sequences a serial "010"-style pattern recognizer over a framed stream of parallel words. It accepts words over a valid/ready handshake and serializes each one MSB-first into an internal pattern-history register, one bit per cycle. It counts pattern matches across the whole frame and signals frame completion. It sits between a word-wide producer and the bit-serial detection logic, and owns arming, clearing and frame sequencing for it.

---
 rtl/seq_scan_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/seq_scan_ctrl.sv
// Frame sequencer for a bit-serial pattern recognizer: words are serialized MSB-first into a
// pattern history and matches are counted per frame. Define SEQ_SCAN_NONOVERLAP_EN for non-overlapping matches.
module seq_scan_ctrl #(
    parameter int               WORD_W = 8,
    parameter int               PAT_W  = 3,
    parameter logic [PAT_W-1:0] PAT    = 3'b010,
    parameter int               CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              busy,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count,
    output logic              overflow,
    output logic              done
);

    localparam int BIT_CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam int VCNT_W    = $clog2(PAT_W + 1);
    localparam logic [VCNT_W-1:0]    VCNT_FULL = VCNT_W'(PAT_W);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(WORD_W - 1);

    typedef enum logic [1:0] {IDLE, ARMED, SHIFT, DONE} state_t;

    state_t                 state_reg;
    logic [WORD_W-1:0]      word_reg;
    logic                   last_reg;
    logic [PAT_W-1:0]       hist_reg;
    logic [VCNT_W-1:0]      vcnt_reg;
    logic [BIT_CNT_W-1:0]   bit_cnt_reg;

    logic [PAT_W-1:0]       hist_next;
    logic [VCNT_W-1:0]      vcnt_next;
    logic                   is_match;

    // The bit being shifted this cycle is always the MSB of the (left-shifting) word register.
    assign hist_next = {hist_reg[PAT_W-2:0], word_reg[WORD_W-1]};
    assign vcnt_next = (vcnt_reg == VCNT_FULL) ? vcnt_reg : vcnt_reg + 1'b1;
    assign is_match  = (vcnt_next == VCNT_FULL) && (hist_next == PAT);

    assign in_ready = (state_reg == ARMED);
    assign busy     = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            word_reg    <= '0;
            last_reg    <= 1'b0;
            hist_reg    <= '0;
            vcnt_reg    <= '0;
            bit_cnt_reg <= '0;
            match_pulse <= 1'b0;
            match_count <= '0;
            overflow    <= 1'b0;
            done        <= 1'b0;
        end else begin
            match_pulse <= 1'b0;
            done        <= 1'b0;
            if (clear) begin
                state_reg   <= IDLE;
                match_count <= '0;
                overflow    <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            state_reg   <= ARMED;
                            match_count <= '0;
                            overflow    <= 1'b0;
                            vcnt_reg    <= '0;
                            hist_reg    <= '0;
                        end
                    end
                    ARMED: begin
                        if (in_valid) begin
                            word_reg    <= in_data;
                            last_reg    <= in_last;
                            bit_cnt_reg <= '0;
                            state_reg   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        word_reg <= word_reg << 1;
                        hist_reg <= hist_next;
                        vcnt_reg <= vcnt_next;
                        if (is_match) begin
                            match_pulse <= 1'b1;
                            if (match_count == {CNT_W{1'b1}})
                                overflow <= 1'b1;
                            else
                                match_count <= match_count + 1'b1;
`ifdef SEQ_SCAN_NONOVERLAP_EN
                            vcnt_reg <= '0;
`endif
                        end
                        if (bit_cnt_reg == BIT_LAST) begin
                            state_reg <= last_reg ? DONE : ARMED;
                            done      <= last_reg;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                    DONE: begin
                        state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule
